// File: rtl/vtg_pkg.sv
// vtg_pkg: shared 640x480@60 raster constants, colour-bar table
// and the region-total helper used by the video timing generator.
package vtg_pkg;

  localparam int VTG_H_ACTIVE = 640;
  localparam int VTG_H_FP     = 16;
  localparam int VTG_H_SYNC   = 96;
  localparam int VTG_H_BP     = 48;
  localparam int VTG_V_ACTIVE = 480;
  localparam int VTG_V_FP     = 10;
  localparam int VTG_V_SYNC   = 2;
  localparam int VTG_V_BP     = 33;
  localparam int VTG_CW       = 12;

  function automatic int vtg_total(
    input int act,
    input int fp,
    input int sync,
    input int bp
  );
    return act + fp + sync + bp;
  endfunction

  // bars left to right: white yellow cyan green magenta red blue black
  function automatic logic [23:0] vtg_bar_rgb(
    input logic [2:0] idx
  );
    logic [23:0] c;
    unique case (idx)
      3'd0: c = 24'hffffff;
      3'd1: c = 24'hffff00;
      3'd2: c = 24'h00ffff;
      3'd3: c = 24'h00ff00;
      3'd4: c = 24'hff00ff;
      3'd5: c = 24'hff0000;
      3'd6: c = 24'h0000ff;
      3'd7: c = 24'h000000;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vtg_axis_counter.sv
// vtg_axis_counter: one raster axis (active, FP, sync, BP).
// Ports: clk_in, reset (async high), step -> count, wrap, active, sync.
module vtg_axis_counter
  import vtg_pkg::*;
#(
  parameter int ACTIVE = 640,
  parameter int FP     = 16,
  parameter int SYNC   = 96,
  parameter int BP     = 48,
  parameter int CW     = 12
) (
  input  logic          clk_in,
  input  logic          reset,
  input  logic          step,
  output logic [CW-1:0] count,
  output logic          wrap,
  output logic          active,
  output logic          sync
);

  localparam int TOTAL   = vtg_total(ACTIVE, FP, SYNC, BP);
  localparam int SYNC_LO = ACTIVE + FP;
  localparam int SYNC_HI = ACTIVE + FP + SYNC;
  localparam logic [CW-1:0] LAST = CW'(TOTAL - 1);

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (step) begin
      count <= wrap ? '0 : count + 1'b1;
    end
  end

  // compare in 32 bits: region edges may equal 2**CW
  assign wrap   = (count == LAST);
  assign active = (int'(count) < ACTIVE);
  assign sync   = (int'(count) >= SYNC_LO)
               && (int'(count) < SYNC_HI);

endmodule

// File: rtl/video_timing_gen.sv
// video_timing_gen: parametrised raster timing for the ADV7513 path.
// Ports: clk_in, reset, enable -> pix_x/pix_y, de, hsync, vsync,
//   line_start, frame_start, frame_count, rgb (VTG_PATTERN_EN only).
module video_timing_gen
  import vtg_pkg::*;
#(
  parameter int H_ACTIVE = VTG_H_ACTIVE,
  parameter int H_FP     = VTG_H_FP,
  parameter int H_SYNC   = VTG_H_SYNC,
  parameter int H_BP     = VTG_H_BP,
  parameter int V_ACTIVE = VTG_V_ACTIVE,
  parameter int V_FP     = VTG_V_FP,
  parameter int V_SYNC   = VTG_V_SYNC,
  parameter int V_BP     = VTG_V_BP,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CW       = VTG_CW
) (
  input  logic          clk_in,
  input  logic          reset,
  input  logic          enable,
  output logic [CW-1:0] pix_x,
  output logic [CW-1:0] pix_y,
  output logic          de,
  output logic          hsync,
  output logic          vsync,
  output logic          line_start,
  output logic          frame_start,
  output logic [15:0]   frame_count
`ifdef VTG_PATTERN_EN
  ,
  output logic [23:0]   rgb
`endif
);

  localparam int H_TOTAL =
    vtg_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL =
    vtg_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  if (H_TOTAL > (1 << CW)) begin : g_h_chk
    $error("H_TOTAL does not fit in CW");
  end
  if (V_TOTAL > (1 << CW)) begin : g_v_chk
    $error("V_TOTAL does not fit in CW");
  end

  logic [CW-1:0] h;
  logic [CW-1:0] v;
  logic          h_wrap;
  logic          v_wrap;
  logic          h_act;
  logic          v_act;
  logic          h_sync;
  logic          v_sync;
  logic          v_step;

  assign v_step = enable & h_wrap;

  vtg_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .CW     (CW)
  ) u_h (
    .clk_in (clk_in),
    .reset  (reset),
    .step   (enable),
    .count  (h),
    .wrap   (h_wrap),
    .active (h_act),
    .sync   (h_sync)
  );

  vtg_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .CW     (CW)
  ) u_v (
    .clk_in (clk_in),
    .reset  (reset),
    .step   (v_step),
    .count  (v),
    .wrap   (v_wrap),
    .active (v_act),
    .sync   (v_sync)
  );

  // outputs mirror the counter state seen at this edge
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      pix_x       <= '0;
      pix_y       <= '0;
      de          <= 1'b0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_count <= '0;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (enable) begin
        pix_x       <= h;
        pix_y       <= v;
        de          <= h_act & v_act;
        hsync       <= h_sync ? HS_POL : ~HS_POL;
        vsync       <= v_sync ? VS_POL : ~VS_POL;
        line_start  <= (h == '0);
        frame_start <= (h == '0) && (v == '0);
        if (h_wrap && v_wrap) begin
          frame_count <= frame_count + 16'd1;
        end
      end
    end
  end

`ifdef VTG_PATTERN_EN
  // narrow rasters get 1-pixel bars; the last bar soaks up the rest
  localparam int BAR_W =
    (H_ACTIVE / 8 < 1) ? 1 : H_ACTIVE / 8;

  logic [2:0] bar_idx;

  always_comb begin
    bar_idx = 3'd7;
    if (int'(h) / BAR_W < 7) begin
      bar_idx = 3'(int'(h) / BAR_W);
    end
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      rgb <= '0;
    end else if (enable) begin
      rgb <= (h_act & v_act) ? vtg_bar_rgb(bar_idx) : '0;
    end
  end
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: scoreboard bench for video_timing_gen,
// default 640x480 instance plus a tiny 7x6 instance with high syncs.
module tb_video_timing_gen;

  typedef struct packed {
    logic [11:0] x;
    logic [11:0] y;
    logic        de;
    logic        hs;
    logic        vs;
    logic        ls;
    logic        fs;
    logic [15:0] fc;
    logic [23:0] rgb;
  } obs_t;

  logic clk;
  logic reset;
  logic enable;

  logic [11:0] d0_x, d0_y, d1_x, d1_y;
  logic        d0_de, d0_hs, d0_vs, d0_ls, d0_fs;
  logic        d1_de, d1_hs, d1_vs, d1_ls, d1_fs;
  logic [15:0] d0_fc, d1_fc;
  logic [23:0] d0_rgb, d1_rgb;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int p_ha[2] = '{640, 4};
  int p_hf[2] = '{16, 1};
  int p_hs[2] = '{96, 1};
  int p_hb[2] = '{48, 1};
  int p_va[2] = '{480, 3};
  int p_vf[2] = '{10, 1};
  int p_vs[2] = '{2, 1};
  int p_vb[2] = '{33, 1};
  bit p_hp[2] = '{1'b0, 1'b1};
  bit p_vp[2] = '{1'b0, 1'b1};

  logic [23:0] bars[8] = '{
    24'hffffff, 24'hffff00, 24'h00ffff, 24'h00ff00,
    24'hff00ff, 24'hff0000, 24'h0000ff, 24'h000000
  };

  int          mh[2];
  int          mv[2];
  logic [15:0] mfc[2];
  obs_t        mlast[2];

  obs_t q0[$];
  obs_t q1[$];

  video_timing_gen u_def (
    .clk_in      (clk),
    .reset       (reset),
    .enable      (enable),
    .pix_x       (d0_x),
    .pix_y       (d0_y),
    .de          (d0_de),
    .hsync       (d0_hs),
    .vsync       (d0_vs),
    .line_start  (d0_ls),
    .frame_start (d0_fs),
    .frame_count (d0_fc)
`ifdef VTG_PATTERN_EN
    ,
    .rgb         (d0_rgb)
`endif
  );

  video_timing_gen #(
    .H_ACTIVE (4), .H_FP (1), .H_SYNC (1), .H_BP (1),
    .V_ACTIVE (3), .V_FP (1), .V_SYNC (1), .V_BP (1),
    .HS_POL   (1'b1), .VS_POL (1'b1)
  ) u_tiny (
    .clk_in      (clk),
    .reset       (reset),
    .enable      (enable),
    .pix_x       (d1_x),
    .pix_y       (d1_y),
    .de          (d1_de),
    .hsync       (d1_hs),
    .vsync       (d1_vs),
    .line_start  (d1_ls),
    .frame_start (d1_fs),
    .frame_count (d1_fc)
`ifdef VTG_PATTERN_EN
    ,
    .rgb         (d1_rgb)
`endif
  );

`ifndef VTG_PATTERN_EN
  assign d0_rgb = '0;
  assign d1_rgb = '0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [79:0] got,
    input logic [79:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic obs_t rst_obs(input int i);
    obs_t o;
    o     = '0;
    o.hs  = ~p_hp[i];
    o.vs  = ~p_vp[i];
    return o;
  endfunction

  function automatic obs_t dut_obs(input int i);
    if (i == 0)
      return {d0_x, d0_y, d0_de, d0_hs, d0_vs,
              d0_ls, d0_fs, d0_fc, d0_rgb};
    return {d1_x, d1_y, d1_de, d1_hs, d1_vs,
            d1_ls, d1_fs, d1_fc, d1_rgb};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mh[i]    = 0;
      mv[i]    = 0;
      mfc[i]   = '0;
      mlast[i] = rst_obs(i);
    end
  endtask

  task automatic model_edge(input int i, input bit en,
                            output obs_t o);
    int ht, vt, bw, bi, hlo, vlo;
    ht  = p_ha[i] + p_hf[i] + p_hs[i] + p_hb[i];
    vt  = p_va[i] + p_vf[i] + p_vs[i] + p_vb[i];
    hlo = p_ha[i] + p_hf[i];
    vlo = p_va[i] + p_vf[i];
    o    = mlast[i];
    o.ls = 1'b0;
    o.fs = 1'b0;
    if (en) begin
      o.x  = 12'(mh[i]);
      o.y  = 12'(mv[i]);
      o.de = (mh[i] < p_ha[i]) && (mv[i] < p_va[i]);
      o.hs = (mh[i] >= hlo && mh[i] < hlo + p_hs[i])
           ? p_hp[i] : ~p_hp[i];
      o.vs = (mv[i] >= vlo && mv[i] < vlo + p_vs[i])
           ? p_vp[i] : ~p_vp[i];
      o.ls = (mh[i] == 0);
      o.fs = (mh[i] == 0) && (mv[i] == 0);
      bw = (p_ha[i] / 8 < 1) ? 1 : p_ha[i] / 8;
      bi = mh[i] / bw;
      if (bi > 7) bi = 7;
      o.rgb = o.de ? bars[bi] : 24'h0;
      if (mh[i] == ht - 1 && mv[i] == vt - 1) mfc[i]++;
      o.fc = mfc[i];
      mh[i]++;
      if (mh[i] == ht) begin
        mh[i] = 0;
        mv[i]++;
        if (mv[i] == vt) mv[i] = 0;
      end
    end
`ifndef VTG_PATTERN_EN
    o.rgb = '0;
`endif
    mlast[i] = o;
  endtask

  task automatic tick();
    obs_t e;
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        model_reset();
        e = rst_obs(i);
      end else begin
        model_edge(i, enable, e);
      end
      if (i == 0) q0.push_back(e);
      else q1.push_back(e);
    end
    @(posedge clk);
    #1;
    cyc++;
    check("sb_def", dut_obs(0), q0.pop_front());
    check("sb_tiny", dut_obs(1), q1.pop_front());
  endtask

  initial begin
    int n, de_n, hs_n, ls_n, vs_n, fs_n, fs_cyc;
    reset  = 1'b1;
    enable = 1'b0;
    model_reset();
    #2;
    check("rst_def", dut_obs(0), rst_obs(0));
    check("rst_tiny", dut_obs(1), rst_obs(1));
    tick();
    tick();
    reset  = 1'b0;
    enable = 1'b1;

    de_n = 0;
    hs_n = 0;
    ls_n = 0;
    for (int k = 0; k < 800; k++) begin
      tick();
      if (k == 0) check("first_fs", d0_fs, 1);
      de_n += int'(d0_de);
      hs_n += int'(!d0_hs);
      ls_n += int'(d0_ls);
    end
    check("de_cnt", de_n, 640);
    check("hs_low_cnt", hs_n, 96);
    check("ls_cnt", ls_n, 1);
    tick();
    check("ls_period", d0_ls, 1);
    check("line1_y", d0_y, 1);

    n = 0;
    while (d0_x != 12'd100 && n < 1000) begin
      tick();
      n++;
    end
    check("reach_x100", d0_x, 100);
    enable = 1'b0;
    ls_n = 0;
    for (int k = 0; k < 50; k++) begin
      tick();
      ls_n += int'(d0_ls) + int'(d0_fs);
    end
    check("frz_x", d0_x, 100);
    check("frz_strobes", ls_n, 0);
    enable = 1'b1;
    tick();
    check("resume_x", d0_x, 101);

    n = 0;
    while (d0_x != 12'd300 && n < 1000) begin
      tick();
      n++;
    end
    check("reach_x300", d0_x, 300);
    reset = 1'b1;
    #1;
    check("arst_def", dut_obs(0), rst_obs(0));
    check("arst_tiny", dut_obs(1), rst_obs(1));
    model_reset();
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("restart_fs", d0_fs, 1);
    check("restart_fs_tiny", d1_fs, 1);

    vs_n   = 0;
    fs_n   = 0;
    fs_cyc = cyc;
    for (int k = 0; k < 84; k++) begin
      tick();
      vs_n += int'(d1_vs);
      if (d1_fs) begin
        fs_n++;
        check("t_fs_period", cyc - fs_cyc, 42);
        check("t_fc", d1_fc, fs_n);
        fs_cyc = cyc;
      end
    end
    check("t_fs_cnt", fs_n, 2);
    check("t_vs_cnt", vs_n, 14);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
